// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  // Width of a counter that must hold values 0..maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the IF/DM ports: DM has priority; with ARB_STARVE_GUARD_EN
// a saturating loss counter forces IF through after STARVE_MAX consecutive losses.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  logic force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = cnt_w(STARVE_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign force_if = if_req && dm_req && (starve_cnt == SMAX);

  // Counts only real arbitration losses, so held requests during ISSUE/WAIT don't count.
  always_ff @(posedge clock) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_if)
      starve_cnt <= '0;
    else if (grant_dm && if_req && (starve_cnt != SMAX))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_guard;
  assign unused_guard = ^{clock, reset, (STARVE_MAX != 0)};
  assign force_if     = 1'b0;
`endif

  assign grant_dm = arb_en && dm_req && !force_if;
  assign grant_if = arb_en && if_req && !grant_dm;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and data (DM) ports,
// one transaction at a time. Optional fetch-starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = cnt_w(MEM_LAT);

  state_t            state, state_nxt;
  owner_t            owner;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] resp_q;
  logic              arb_en, grant_if, grant_dm, resp_cyc;

  // Word addressing wraps inside the memory; byte offset bits are dropped.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  assign arb_en = !reset && ((state == IDLE) || (state == RESP));

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clock   (clock),
    .reset   (reset),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (grant_if || grant_dm) ? ISSUE : IDLE;
      ISSUE:      state_nxt = WAIT;
      WAIT:       if (wait_cnt == CNT_W'(1)) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_ready  = grant_if;
    dm_ready  = grant_dm;
    resp_cyc  = (state == RESP) && !reset;
    if_rvalid = resp_cyc && (owner == OWN_IF);
    dm_rvalid = resp_cyc && (owner == OWN_DM);
    if_rdata  = if_rvalid ? resp_q : '0;
    dm_rdata  = dm_rvalid ? resp_q : '0;
    busy      = (state != IDLE);
  end

  // The mem_* registers double as the latched command; they hold between accesses.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= OWN_IF;
      wait_cnt  <= '0;
      resp_q    <= '0;
    end else begin
      mem_en <= grant_if || grant_dm;
      if (grant_dm) begin
        owner     <= OWN_DM;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr[ADDR_W+1:2];
        mem_wdata <= dm_wdata;
      end else if (grant_if) begin
        owner    <= OWN_IF;
        mem_we   <= 1'b0;
        mem_addr <= if_addr[ADDR_W+1:2];
      end
      if (state == ISSUE)
        wait_cnt <= CNT_W'(MEM_LAT);
      else if (state == WAIT)
        wait_cnt <= wait_cnt - 1'b1;
      if ((state == WAIT) && (wait_cnt == CNT_W'(1)))
        resp_q <= mem_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port (IF) and data port (DM, used for LW/SW).
- Handles one transaction at a time. The data port has priority; an optional guard prevents fetch starvation.
- Sits between the CPU pipeline stages and the unified memory. It replaces the separate instruction and data memory arrays.

## Interface
Parameters:
- ADDR_W, 10: memory word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 2: cycles from `mem_en` to valid `mem_rdata`. Must be ≥1.
- STARVE_MAX, 3: consecutive IF losses tolerated before IF is forced to win. Used only with the guard.

Ports:
- clock  in  1  Sole clock. Rising edge.
- reset  in  1  Synchronous, active-high reset.
- if_req  in  1  Fetch request. Held until `if_ready`.
- if_addr  in  32  Fetch byte address.
- if_ready  out  1  Fetch request accepted this cycle (combinational).
- if_rvalid  out  1  One-cycle pulse: `if_rdata` valid.
- if_rdata  out  DATA_W  Fetched word.
- dm_req  in  1  Data request. Held until `dm_ready`.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  Data byte address.
- dm_wdata  in  DATA_W  Store data.
- dm_ready  out  1  Data request accepted this cycle (combinational).
- dm_rvalid  out  1  One-cycle pulse: load data valid, or store complete.
- dm_rdata  out  DATA_W  Load data. 0 for stores.
- mem_en  out  1  Memory access strobe. Registered.
- mem_we  out  1  Memory write enable. Registered.
- mem_addr  out  ADDR_W  Word address = byte address [ADDR_W+1:2]. Registered.
- mem_wdata  out  DATA_W  Registered.
- mem_rdata  in  DATA_W  Valid MEM_LAT cycles after `mem_en`.
- busy  out  1  High whenever the state is not IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

State behaviour:
- **IDLE / RESP:** arbitrate. If any request is present, assert the winner's ready, latch its command and owner, and go to ISSUE. Otherwise go to IDLE.
- **ISSUE:** `mem_en`=1 for exactly one cycle, with the latched we/addr/wdata. Load the wait counter with MEM_LAT. Go to WAIT.
- **WAIT:** decrement the counter each cycle. On the cycle the counter reaches 1, capture `mem_rdata` into the response register and go to RESP.
- **RESP:** pulse the owner's rvalid with the captured data; stores return 0. Arbitration runs in this same cycle.

Arbitration:
- DM request present → DM wins. Otherwise IF wins.
- Only one ready may be high in any cycle.
- A request arriving while the state is ISSUE or WAIT is held by the requester; it gets no ready.

Addressing:
- Address bits [1:0] are ignored (no misalignment fault).
- Address bits above ADDR_W+1 are ignored (wrap-around within the memory).

Other rules:
- A requester deasserting req before ready is legal; nothing is issued for it.
- `mem_we`, `mem_addr` and `mem_wdata` hold their last value when `mem_en`=0.

## Timing
- Grant at cycle T (ready high) → `mem_en` at T+1 → `mem_rdata` sampled at T+1+MEM_LAT → rvalid at T+2+MEM_LAT.
- The next grant may occur at T+2+MEM_LAT.
- Throughput is one transaction per MEM_LAT+2 cycles. With MEM_LAT=2: grant T0, response T4, next grant T4.
- Reset values: state=IDLE; every output 0, including `if_rdata`, `dm_rdata`, `mem_addr`, `mem_wdata` and `busy`; starvation counter 0.
- Reset asserted mid-transaction: the next cycle is IDLE with `mem_en`=0. The pending response is discarded; no rvalid is issued. Requesters must re-request.
- Reset has priority over a grant in the same cycle: ready stays 0 while reset is high.

## Configuration
Macro: ARB_STARVE_GUARD_EN.

When defined:
- A saturating counter (width clog2(STARVE_MAX+1)) increments whenever `if_req` is high but DM wins arbitration.
- It clears when IF is granted.
- When the counter equals STARVE_MAX and both requests are present, IF wins.

When undefined:
- Strict DM priority. IF may starve indefinitely.
- The counter is not instantiated.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner enum (OWN_IF/OWN_DM);
  - default parameter constants.
- Sub-module `mem_arb_pick` (combinational winner select plus the starvation counter) isolates the ARB_STARVE_GUARD_EN logic from the FSM.

## Test plan
1. **Reset, then single fetch.** Reset, then `if_req` at T0 with `if_addr`=0x8.
   - `if_ready` at T0; `mem_en` at T1 with `mem_addr`=2.
   - Memory returns 0x20A51820 → `if_rvalid`=1 with `if_rdata`=0x20A51820 at T4.
2. **Store.** `dm_req`, `dm_we`=1, `dm_addr`=0x10, `dm_wdata`=0xDEADBEEF.
   - `mem_we`=1, `mem_addr`=4 at T1.
   - `dm_rvalid`=1 with `dm_rdata`=0 at T4; `if_rvalid` stays 0.
3. **Simultaneous requests.** `if_req` and `dm_req` both held from T0.
   - DM granted at T0; IF granted at T4.
   - `dm_rvalid` at T4, `if_rvalid` at T8.
4. **Starvation guard.** With ARB_STARVE_GUARD_EN, `dm_req` and `if_req` held continuously.
   - DM is granted 3 times, then IF on the 4th arbitration. Pattern repeats.
   - Without the macro, IF is never granted.
5. **Reset mid-transaction.** Reset asserted in WAIT (T2).
   - T3: `busy`=0, `mem_en`=0, no rvalid.
   - A new `if_req` at T3 is granted at T3.
6. **Address wrap.** `if_addr`=0x1004 with ADDR_W=10 → `mem_addr`=1.
